rv64g_regfile_mp: RTL

- Multi-port, parametrised successor of the core integer/FP register file.
- Each register has a lock counter, so one register can have several writes outstanding at once.
- Any number of read ports, and several independent write (writeback/unlock) ports for multi-issue pipelines.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Sits between issue (lock requests, operand reads) and the writeback ports of the execution units.

---
 rtl/rv64g_regfile_mp.sv | 104 ++++++++++
 1 files changed

// File: rtl/rv64g_regfile_mp.sv
// Multi-port register file with per-register lock counters for multi-issue pipelines.
// Lock requests come from issue; each writeback port writes data and releases one lock.
module rv64g_regfile_mp #(
    parameter int NR       = 32,
    parameter int DW       = 64,
    parameter int NRP      = 3,
    parameter int NWP      = 2,
    parameter int LCW      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 0,
    localparam int AW      = $clog2(NR)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                lock_en_i,
    input  logic [AW-1:0]       lock_addr_i,
    output logic                lock_ready_o,
    input  logic [NWP-1:0]      wr_en_i,
    input  logic [NWP*AW-1:0]   wr_addr_i,
    input  logic [NWP*DW-1:0]   wr_data_i,
    input  logic [NRP*AW-1:0]   rd_addr_i,
    output logic [NRP*DW-1:0]   rd_data_o,
    output logic [NR-1:0]       locks_o
);

    logic [DW-1:0]  regs_q [NR];
    logic [DW-1:0]  regs_d [NR];
    logic [LCW-1:0] cnt_q  [NR];
    logic [LCW-1:0] cnt_d  [NR];
    logic           lock_acc;

    // Readiness looks only at the stored counter, never at same-cycle unlocks.
    assign lock_ready_o = ((ZERO_REG != 0) && (lock_addr_i == '0)) || (cnt_q[lock_addr_i] != '1);
    assign lock_acc     = lock_en_i && lock_ready_o;

    always_comb begin : next_state
        int nxt;
        // NOTE: combinational targets get a default before any conditional update, so no latch is inferred.
        nxt = 0;
        for (int r = 0; r < NR; r++) begin
            regs_d[r] = regs_q[r];
            nxt       = int'(cnt_q[r]);
            if (lock_acc && (lock_addr_i == AW'(r)))
                nxt = nxt + 1;
            // Ascending scan: the highest-index port hitting r wins the data.
            for (int k = 0; k < NWP; k++) begin
                if (wr_en_i[k] && (wr_addr_i[k*AW +: AW] == AW'(r))) begin
                    nxt       = nxt - 1;
                    regs_d[r] = wr_data_i[k*DW +: DW];
                end
            end
            if (nxt < 0)
                nxt = 0;
            if ((ZERO_REG != 0) && (r == 0)) begin
                nxt       = 0;
                regs_d[r] = '0;
            end
            cnt_d[r] = LCW'(nxt);
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: the data array is built from flops and cleared on reset so reads return 0 afterwards.
        if (rst_i) begin
            for (int r = 0; r < NR; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < NR; r++) begin
                regs_q[r] <= regs_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
        end
    end

    always_comb begin : lock_flags
        locks_o = '0;
        for (int r = 0; r < NR; r++)
            locks_o[r] = (cnt_q[r] != '0);
    end

    always_comb begin : read_ports
        logic [AW-1:0] ra;
        logic [DW-1:0] rv;
        ra        = '0;
        rv        = '0;
        rd_data_o = '0;
        for (int p = 0; p < NRP; p++) begin
            ra = rd_addr_i[p*AW +: AW];
            rv = regs_q[ra];
            if (BYPASS != 0) begin
                for (int k = 0; k < NWP; k++) begin
                    if (wr_en_i[k] && (wr_addr_i[k*AW +: AW] == ra))
                        rv = wr_data_i[k*DW +: DW];
                end
            end
            if ((ZERO_REG != 0) && (ra == '0))
                rv = '0;
            rd_data_o[p*DW +: DW] = rv;
        end
    end

endmodule
